// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: round-robin arbitration of n_req writers
// onto one registered write port, plus a lo..hi clear sweep after reset or CLR.
module regfile_wr_sched #(
  parameter int unsigned             addr_width = 5,
  parameter int unsigned             data_width = 32,
  parameter int unsigned             lo         = 0,
  parameter int unsigned             hi         = 31,
  parameter int unsigned             n_req      = 4,
  parameter logic [data_width-1:0]   init_val   = '0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [n_req-1:0]              REQ_VALID,
  input  logic [n_req*addr_width-1:0]   REQ_ADDR,
  input  logic [n_req*data_width-1:0]   REQ_DATA,
  output logic [n_req-1:0]              REQ_READY,
  input  logic                          CLR,
  output logic                          BUSY,
  output logic [addr_width-1:0]         RF_ADDR_IN,
  output logic [data_width-1:0]         RF_D_IN,
  output logic                          RF_WE,
  output logic                          ERR_ADDR,
  output logic [$clog2(n_req)-1:0]      ERR_IDX
);

  localparam int unsigned CNT_W = addr_width + 1;
  localparam int unsigned IDX_W = $clog2(n_req);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [IDX_W-1:0]       ptr, ptr_n;
  logic                   we_n, err_n;
  logic [addr_width-1:0]  addr_n;
  logic [data_width-1:0]  d_n;
  logic [IDX_W-1:0]       err_idx_n;

  logic                   any_valid, gnt;
  logic [IDX_W-1:0]       pick, probe;
  logic [addr_width-1:0]  req_addr [n_req];
  logic [data_width-1:0]  req_data [n_req];
  logic [addr_width-1:0]  sel_addr;
  logic [data_width-1:0]  sel_data;
  logic                   below, above, out_of_range;

  for (genvar g = 0; g < n_req; g++) begin : g_unpack
    assign req_addr[g] = REQ_ADDR[g*addr_width +: addr_width];
    assign req_data[g] = REQ_DATA[g*data_width +: data_width];
  end

  // First valid requester at or after ptr, wrapping at n_req-1.
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    probe     = '0;
    for (int unsigned k = 0; k < n_req; k++) begin
      probe = IDX_W'((32'(ptr) + k) % n_req);
      if (!any_valid && REQ_VALID[probe]) begin
        any_valid = 1'b1;
        pick      = probe;
      end
    end
  end

  assign gnt       = any_valid && (state == S_RUN) && !CLR;
  assign REQ_READY = gnt ? (n_req'(1) << pick) : '0;
  assign sel_addr  = req_addr[pick];
  assign sel_data  = req_data[pick];
  assign BUSY      = (state == S_CLEAR);

  // Bounds that cover the whole address space reduce to constant-false.
  if (lo == 0) begin : g_lo_zero
    assign below = 1'b0;
  end else begin : g_lo_cmp
    assign below = sel_addr < addr_width'(lo);
  end

  if (hi >= (2 ** addr_width) - 1) begin : g_hi_full
    assign above = 1'b0;
  end else begin : g_hi_cmp
    assign above = sel_addr > addr_width'(hi);
  end

  assign out_of_range = below || above;

  // Next-state and registered-output values.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    we_n      = 1'b0;
    addr_n    = RF_ADDR_IN;
    d_n       = RF_D_IN;
    err_n     = 1'b0;
    err_idx_n = ERR_IDX;
    unique case (state)
      S_CLEAR: begin
        we_n   = 1'b1;
        addr_n = cnt[addr_width-1:0];
        d_n    = init_val;
        cnt_n  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(hi)) state_n = S_RUN;
      end
      S_RUN: begin
        if (CLR) begin
          state_n = S_CLEAR;
          cnt_n   = CNT_W'(lo);
        end else if (any_valid) begin
          ptr_n = (pick == IDX_W'(n_req - 1)) ? '0 : pick + IDX_W'(1);
          if (out_of_range) begin
            err_n     = 1'b1;
            err_idx_n = pick;
          end else begin
            we_n   = 1'b1;
            addr_n = sel_addr;
            d_n    = sel_data;
          end
        end
      end
      default: begin
        state_n = S_CLEAR;
        cnt_n   = CNT_W'(lo);
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_CLEAR;
      cnt        <= CNT_W'(lo);
      ptr        <= '0;
      RF_WE      <= 1'b0;
      RF_ADDR_IN <= '0;
      RF_D_IN    <= '0;
      ERR_ADDR   <= 1'b0;
      ERR_IDX    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ptr        <= ptr_n;
      RF_WE      <= we_n;
      RF_ADDR_IN <= addr_n;
      RF_D_IN    <= d_n;
      ERR_ADDR   <= err_n;
      ERR_IDX    <= err_idx_n;
    end
  end

endmodule
